// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding is visible on state_o, so the enum values are fixed.
package hazard_pkg;

  localparam int WAIT_MAX    = 255;
  localparam int STALL_CNT_W = 16;
  localparam int WAIT_CNT_W  = 8;
  localparam int REG_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  // Pipeline steering bundle produced each cycle by the controller.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
    logic mem_wb_bubble;
  } ctrl_t;

  // r0 is hardwired to zero, so a load into it never creates a dependency.
  function automatic logic load_use_hit(
    input logic             mem_read,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt
  );
    return mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Count visible one cycle after the increment request.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flush,
// data-memory freeze with timeout into a sticky error state.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   ID_EX_memRead_i,
  input  logic [REG_W-1:0]       ID_EX_RegRt_i,
  input  logic [REG_W-1:0]       IF_ID_RegRs_i,
  input  logic [REG_W-1:0]       IF_ID_RegRt_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  output logic                   pc_write_o,
  output logic                   IF_ID_write_o,
  output logic                   IF_ID_flush_o,
  output logic                   ID_EX_bubble_o,
  output logic                   pipe_hold_o,
  output logic                   MEM_WB_bubble_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   err_o,
  output logic [1:0]             state_o
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  ctrl_t                 ctrl;
  logic                  active;
  logic                  freeze;
  logic                  loaduse;
  logic                  stall_inc;

  assign active  = (state_q == ST_RUN) || (state_q == ST_MEMWAIT);
  // A zero-latency ack completes the access in the same cycle, so no freeze.
  assign freeze  = active && mem_req_i && !mem_ack_i;
  assign loaduse = (state_q == ST_RUN) &&
                   load_use_hit(ID_EX_memRead_i, ID_EX_RegRt_i, IF_ID_RegRs_i, IF_ID_RegRt_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    ctrl       = '0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_MEMWAIT: begin
        // A taken branch masked by a stall simply re-resolves next cycle.
        if (freeze) begin
          ctrl.pipe_hold     = 1'b1;
          ctrl.mem_wb_bubble = 1'b1;
        end else if (loaduse) begin
          ctrl.id_ex_bubble  = 1'b1;
        end else begin
          ctrl.pc_write      = 1'b1;
          ctrl.if_id_write   = 1'b1;
          ctrl.if_id_flush   = branch_taken_i;
        end

        if (state_q == ST_RUN) begin
          if (freeze) begin
            state_d    = ST_MEMWAIT;
            wait_cnt_d = '0;
          end
        end else if (mem_ack_i) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_CNT_W'(WAIT_MAX)) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_ERROR: begin
        ctrl.pipe_hold     = 1'b1;
        ctrl.mem_wb_bubble = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stall_inc = active && !ctrl.pc_write;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  assign pc_write_o      = ctrl.pc_write;
  assign IF_ID_write_o   = ctrl.if_id_write;
  assign IF_ID_flush_o   = ctrl.if_id_flush;
  assign ID_EX_bubble_o  = ctrl.id_ex_bubble;
  assign pipe_hold_o     = ctrl.pipe_hold;
  assign MEM_WB_bubble_o = ctrl.mem_wb_bubble;
  assign err_o           = (state_q == ST_ERROR);
  assign state_o         = state_q;

endmodule
